// File: rtl/seq_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator (unsigned / two's complement) with an h/e/l result.
// Optional macro SEQ_CMP_EARLY_EXIT_EN ends the run on the first differing bit.
module seq_mag_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             h,
   output logic             e,
   output logic             l
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDX_W-1:0] r_idx;
   logic             r_signed;
   logic             r_decided;
   logic             r_gt;
   logic             r_h;
   logic             r_e;
   logic             r_l;

   logic w_abit;
   logic w_bbit;
   logic w_diff;
   logic w_msb;
   logic w_bit_gt;
   logic w_dec;
   logic w_gt;
   logic w_last;

   assign w_abit   = r_a[r_idx];
   assign w_bbit   = r_b[r_idx];
   assign w_diff   = w_abit ^ w_bbit;
   assign w_msb    = (r_idx == IDX_W'(WIDTH - 1));
   // A differing sign bit reverses the order: the operand with sign 0 is larger
   assign w_bit_gt = (w_msb && r_signed) ? w_bbit : w_abit;
   assign w_dec    = r_decided | w_diff;
   assign w_gt     = r_decided ? r_gt : w_bit_gt;

`ifdef SEQ_CMP_EARLY_EXIT_EN
   assign w_last = (r_idx == '0) || w_diff;
`else
   assign w_last = (r_idx == '0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_idx     <= '0;
         r_signed  <= 1'b0;
         r_decided <= 1'b0;
         r_gt      <= 1'b0;
         r_h       <= 1'b0;
         r_e       <= 1'b0;
         r_l       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a       <= a;
                  r_b       <= b;
                  r_signed  <= signed_mode;
                  r_idx     <= IDX_W'(WIDTH - 1);
                  r_decided <= 1'b0;
                  r_gt      <= 1'b0;
               end
            end
            S_RUN: begin
               r_decided <= w_dec;
               r_gt      <= w_gt;
               if (r_idx != '0) begin
                  r_idx <= r_idx - IDX_W'(1);
               end
               // Result registers change only at completion and hold across new starts
               if (w_last) begin
                  r_h <= w_dec & w_gt;
                  r_e <= ~w_dec;
                  r_l <= w_dec & ~w_gt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign h = r_h;
   assign e = r_e;
   assign l = r_l;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator: a WIDTH=8 instance for directed cases and a
// WIDTH=4 instance for an exhaustive sweep; expected latency follows SEQ_CMP_EARLY_EXIT_EN.
module tb_seq_mag_comparator;

   typedef struct {
      logic [2:0] hel;
      int         k;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0, sm8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, h8, e8, l8;
   logic       start4 = 1'b0, sm4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, h4, e4, l4;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q8[$];
   exp_t q4[$];
   logic [2:0] last8 = 3'b000;
   logic [2:0] last4 = 3'b000;

   seq_mag_comparator #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .h(h8), .e(e8), .l(l8)
   );

   seq_mag_comparator #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .h(h4), .e(e4), .l(l4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input bit sm, input int w);
      longint sa, sb;
      sa = longint'(a);
      sb = longint'(b);
      if (sm && a[w-1]) sa = sa - (longint'(1) << w);
      if (sm && b[w-1]) sb = sb - (longint'(1) << w);
      if (sa > sb) return 3'b100;
      if (sa == sb) return 3'b010;
      return 3'b001;
   endfunction

   function automatic int lat_of(input logic [7:0] a, input logic [7:0] b, input int w);
`ifdef SEQ_CMP_EARLY_EXIT_EN
      for (int i = w - 1; i >= 0; i--) begin
         if (a[i] != b[i]) return w - i;
      end
`endif
      return w;
   endfunction

   // Result monitors
   always @(negedge clk) begin
      if (!rst) begin
         if (done8) begin
            if (q8.size() == 0) begin
               chk("d8_spurious_done", 32'd1, 32'd0);
            end else begin
               exp_t x;
               x = q8.pop_front();
               chk("d8_hel", {29'd0, h8, e8, l8}, {29'd0, x.hel});
               chk("d8_latency", 32'(cyc - x.k), 32'(x.lat));
               chk("d8_busy_in_done", {31'd0, busy8}, 32'd0);
               last8 = x.hel;
            end
         end else if (q8.size() > 0 && cyc >= q8[0].k) begin
            chk("d8_busy_in_run", {31'd0, busy8}, 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && done4) begin
         if (q4.size() == 0) begin
            chk("d4_spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = q4.pop_front();
            chk("d4_hel", {29'd0, h4, e4, l4}, {29'd0, x.hel});
            chk("d4_latency", 32'(cyc - x.k), 32'(x.lat));
            last4 = x.hel;
         end
      end
   end

   task automatic wait_empty(input bit sel);
      int n;
      n = 0;
      while (((sel ? q4.size() : q8.size()) != 0) && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if ((sel ? q4.size() : q8.size()) != 0) begin
         chk(sel ? "d4_done_timeout" : "d8_done_timeout", 32'd1, 32'd0);
         if (sel) q4.delete(); else q8.delete();
      end
      @(negedge clk);
   endtask

   // Launch one comparison; optionally inject an ignored start mid-run
   task automatic go(input bit sel, input logic [7:0] a, input logic [7:0] b, input bit sm,
                     input bit wait_done, input bit inject);
      exp_t x;
      @(negedge clk);
      x.k = cyc + 1;
      if (sel) begin
         a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; start4 = 1'b1;
         x.hel = model(a, b, sm, 4);
         x.lat = lat_of(a, b, 4);
         q4.push_back(x);
      end else begin
         a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
         x.hel = model(a, b, sm, 8);
         x.lat = lat_of(a, b, 8);
         q8.push_back(x);
      end
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
      a8 = ~a8; b8 = 8'h5C; a4 = ~a4; b4 = 4'h9;
      if (!sel) begin
         if (x.lat > 1) chk("d8_hold_after_start", {29'd0, h8, e8, l8}, {29'd0, last8});
         if (inject) begin
            @(negedge clk);
            a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
         end
      end
      if (wait_done) wait_empty(sel);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy8}, 32'd0);
      chk("rst_done", {31'd0, done8}, 32'd0);
      chk("rst_hel8", {29'd0, h8, e8, l8}, 32'd0);
      chk("rst_hel4", {29'd0, h4, e4, l4}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      go(1'b0, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0);
      go(1'b0, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0);
      go(1'b0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);
      go(1'b0, 8'h5A, 8'h5A, 1'b1, 1'b1, 1'b0);
      go(1'b0, 8'h03, 8'h02, 1'b0, 1'b1, 1'b1);
      go(1'b0, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
      go(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
      go(1'b0, 8'h7F, 8'h80, 1'b1, 1'b1, 1'b0);

      // Abort a run at edge k+4 with an asynchronous reset
      go(1'b0, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
      begin
         int k;
         k = q8[0].k;
         while (cyc < k + 4) @(posedge clk);
         #1;
         rst = 1'b1;
         #1;
         chk("abort_hel", {29'd0, h8, e8, l8}, 32'd0);
         chk("abort_busy", {31'd0, busy8}, 32'd0);
         chk("abort_done", {31'd0, done8}, 32'd0);
         q8.delete();
         last8 = 3'b000;
         last4 = 3'b000;
         @(negedge clk);
         rst = 1'b0;
         repeat (12) @(negedge clk);
      end
      go(1'b0, 8'h03, 8'h02, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         go(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
      end

      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
               go(1'b1, 8'(i), 8'(j), 1'(m), 1'b1, 1'b0);
            end
         end
      end

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
